// File: rtl/cache_mem_arb.sv
// Cache line-fill / writeback arbiter in front of a single-outstanding memory port.
// Alternating priority on ties; WAIT phase guarded by a response timeout.
module cache_mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              fill_gnt,
  output logic              fill_vld,
  output logic [LINE_W-1:0] fill_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0] wb_data,
  output logic              wb_gnt,
  output logic              wb_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic              mem_rvld,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_wack,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state, state_n;
  logic              op_we, op_we_n;
  logic              last_wb, last_wb_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic [LINE_W-1:0] wdata_n, fdata_n;
  logic              fgnt_n, wgnt_n, fvld_n, wdone_n, err_n;
  logic              pick_wb;

  // Writeback wins a tie unless it was also the previous grant.
  assign pick_wb = wb_req && (!fill_req || !last_wb);

  assign mem_req = (state == ISSUE);
  assign mem_we  = op_we;
  assign busy    = (state != IDLE);

  always_comb begin
    state_n   = state;
    op_we_n   = op_we;
    last_wb_n = last_wb;
    cnt_n     = cnt;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    fdata_n   = fill_data;
    fgnt_n    = 1'b0;
    wgnt_n    = 1'b0;
    fvld_n    = 1'b0;
    wdone_n   = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fill_req || wb_req) begin
          op_we_n   = pick_wb;
          last_wb_n = pick_wb;
          addr_n    = pick_wb ? wb_addr : fill_addr;
          wdata_n   = pick_wb ? wb_data : '0;
          fgnt_n    = !pick_wb;
          wgnt_n    = pick_wb;
          state_n   = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rdy) begin
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // A matching response on the final counted cycle still completes.
        if (!op_we && mem_rvld) begin
          fdata_n = mem_rdata;
          fvld_n  = 1'b1;
          state_n = IDLE;
        end else if (op_we && mem_wack) begin
          wdone_n = 1'b1;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_we     <= 1'b0;
      last_wb   <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      fill_data <= '0;
      fill_gnt  <= 1'b0;
      wb_gnt    <= 1'b0;
      fill_vld  <= 1'b0;
      wb_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      op_we     <= op_we_n;
      last_wb   <= last_wb_n;
      cnt       <= cnt_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      fill_data <= fdata_n;
      fill_gnt  <= fgnt_n;
      wb_gnt    <= wgnt_n;
      fill_vld  <= fvld_n;
      wb_done   <= wdone_n;
      err       <= err_n;
    end
  end

endmodule

// File: tb/tb_cache_mem_arb.sv
// Self-checking bench for cache_mem_arb: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_cache_mem_arb;

  localparam int ADDR_W  = 16;
  localparam int LINE_W  = 64;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fill_req, wb_req, mem_rdy, mem_rvld, mem_wack;
  logic [ADDR_W-1:0] fill_addr, wb_addr;
  logic [LINE_W-1:0] wb_data, mem_rdata;
  logic              fill_gnt, fill_vld, wb_gnt, wb_done, mem_req, mem_we, busy, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] fill_data, mem_wdata;

  cache_mem_arb #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_gnt(fill_gnt),
    .fill_vld(fill_vld), .fill_data(fill_data),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_gnt(wb_gnt), .wb_done(wb_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata), .mem_wack(mem_wack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Status word: gnt_f, gnt_w, vld, done, err, busy, mem_req, fill_data.
  logic [LINE_W+6:0]      st;
  logic [ADDR_W+LINE_W:0] mb;
  assign st = {fill_gnt, wb_gnt, fill_vld, wb_done, err, busy, mem_req, fill_data};
  assign mb = {mem_we, mem_addr, mem_wdata};

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state: pending requests as the cache sees them, arbitration history,
  // and the line the cache last received.
  bit                pend_f, pend_w, last_wb, chaos;
  logic [ADDR_W-1:0] f_addr, w_addr;
  logic [LINE_W-1:0] w_data, exp_fill;

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic maybe_new_req();
    if (chaos && !pend_f && $urandom_range(0, 7) == 0) begin
      pend_f = 1'b1; f_addr = ADDR_W'($urandom);
      fill_req = 1'b1; fill_addr = f_addr;
    end
    if (chaos && !pend_w && $urandom_range(0, 7) == 0) begin
      pend_w = 1'b1; w_addr = ADDR_W'($urandom); w_data = rnd_line();
      wb_req = 1'b1; wb_addr = w_addr; wb_data = w_data;
    end
  endtask

  // One complete transaction starting from an IDLE cycle with something pending:
  // d cycles of mem_rdy backpressure, response in WAIT cycle r (r >= TIMEOUT means none).
  task automatic do_txn(input int unsigned d, input int unsigned r,
                        input logic [LINE_W-1:0] rd, input bit stray, output bit gw);
    logic [ADDR_W-1:0] ea;
    logic [LINE_W-1:0] ed;
    gw = pend_w && (!pend_f || !last_wb);
    fill_req = pend_f; fill_addr = f_addr;
    wb_req = pend_w; wb_addr = w_addr; wb_data = w_data;
    mem_rdy = 1'b0; mem_rvld = 1'b0; mem_wack = 1'b0;
    step();
    last_wb = gw;
    ea = gw ? w_addr : f_addr;
    ed = gw ? w_data : '0;
    vectors++;
    if (st !== {!gw, gw, 5'b00011, exp_fill}) begin
      miscompares++; $display("FAIL grant: got %h want %h", st, {!gw, gw, 5'b00011, exp_fill});
    end
    if (gw) begin pend_w = 1'b0; wb_req = 1'b0; end
    else begin pend_f = 1'b0; fill_req = 1'b0; end
    for (int unsigned i = 0; i <= d; i++) begin
      if (i > 0) begin
        vectors++;
        if (st !== {7'b0000011, exp_fill}) begin
          miscompares++; $display("FAIL issue: got %h want %h", st, {7'b0000011, exp_fill});
        end
      end
      vectors++;
      if (mb !== {gw, ea, ed}) begin
        miscompares++; $display("FAIL issue_hold: got %h want %h", mb, {gw, ea, ed});
      end
      maybe_new_req();
      mem_rdy   = (i == d);
      mem_rvld  = stray | 1'($urandom_range(0, 1));
      mem_wack  = stray | 1'($urandom_range(0, 1));
      mem_rdata = rnd_line();
      step();
    end
    mem_rdy = 1'b0;
    for (int unsigned k = 0; k < TIMEOUT; k++) begin
      vectors++;
      if (st !== {7'b0000010, exp_fill}) begin
        miscompares++; $display("FAIL wait: got %h want %h", st, {7'b0000010, exp_fill});
      end
      maybe_new_req();
      mem_rdata = (k == r) ? rd : rnd_line();
      if (gw) begin
        mem_wack = (k == r); mem_rvld = stray | 1'($urandom_range(0, 1));
      end else begin
        mem_rvld = (k == r); mem_wack = stray | 1'($urandom_range(0, 1));
      end
      step();
      if (k == r) break;
    end
    mem_rvld = 1'b0; mem_wack = 1'b0;
    if (r < TIMEOUT) begin
      if (!gw) exp_fill = rd;
      vectors++;
      if (st !== {2'b00, !gw, gw, 3'b000, exp_fill}) begin
        miscompares++; $display("FAIL complete: got %h want %h", st, {2'b00, !gw, gw, 3'b000, exp_fill});
      end
    end else begin
      vectors++;
      if (st !== {7'b0000100, exp_fill}) begin
        miscompares++; $display("FAIL timeout: got %h want %h", st, {7'b0000100, exp_fill});
      end
    end
  endtask

  task automatic idle_cycle(input bit stray);
    fill_req = 1'b0; wb_req = 1'b0;
    mem_rdy   = 1'($urandom_range(0, 1));
    mem_rvld  = stray | 1'($urandom_range(0, 1));
    mem_wack  = stray | 1'($urandom_range(0, 1));
    mem_rdata = rnd_line();
    step();
    mem_rvld = 1'b0; mem_wack = 1'b0; mem_rdy = 1'b0;
    vectors++;
    if (st !== {7'b0000000, exp_fill}) begin
      miscompares++; $display("FAIL idle: got %h want %h", st, {7'b0000000, exp_fill});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fill_req = 1'b1; wb_req = 1'b1; mem_rdy = 1'b1; mem_rvld = 1'b1; mem_wack = 1'b1;
    fill_addr = ADDR_W'($urandom); wb_addr = ADDR_W'($urandom);
    wb_data = rnd_line(); mem_rdata = rnd_line();
    #1;
    vectors++;
    if ({st, mb} !== '0) begin
      miscompares++; $display("FAIL reset_async: got %h %h want 0", st, mb);
    end
    repeat (3) step();
    vectors++;
    if ({st, mb} !== '0) begin
      miscompares++; $display("FAIL reset_hold: got %h %h want 0", st, mb);
    end
    fill_req = 1'b0; wb_req = 1'b0; mem_rdy = 1'b0; mem_rvld = 1'b0; mem_wack = 1'b0;
    rst = 1'b1;
    step();
    pend_f = 1'b0; pend_w = 1'b0; last_wb = 1'b0; exp_fill = '0;
    vectors++;
    if (st !== '0) begin
      miscompares++; $display("FAIL reset_release: got %h want 0", st);
    end
  endtask

  task automatic test_fill_only();
    bit gw;
    pend_f = 1'b1; f_addr = 16'h0100;
    do_txn(0, 0, 64'hA5A5, 1'b0, gw);
  endtask

  task automatic test_tie();
    bit gw;
    test_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      if (!pend_f) begin pend_f = 1'b1; f_addr = ADDR_W'($urandom); end
      if (!pend_w) begin pend_w = 1'b1; w_addr = ADDR_W'($urandom); w_data = rnd_line(); end
      do_txn($urandom_range(0, 2), $urandom_range(0, TIMEOUT - 1), rnd_line(), 1'b0, gw);
    end
    if (pend_f) begin
      do_txn(0, 0, rnd_line(), 1'b0, gw);
    end
  endtask

  task automatic test_backpressure();
    bit gw;
    pend_w = 1'b1; w_addr = ADDR_W'($urandom); w_data = rnd_line();
    do_txn(5, 2, rnd_line(), 1'b0, gw);
    pend_f = 1'b1; f_addr = ADDR_W'($urandom);
    do_txn(5, 0, rnd_line(), 1'b0, gw);
  endtask

  task automatic test_timeout();
    bit gw;
    pend_f = 1'b1; f_addr = ADDR_W'($urandom);
    do_txn(1, TIMEOUT + 3, rnd_line(), 1'b0, gw);
    pend_f = 1'b1; f_addr = ADDR_W'($urandom);
    do_txn(0, 1, rnd_line(), 1'b0, gw);
    pend_f = 1'b1; f_addr = ADDR_W'($urandom);
    do_txn(0, TIMEOUT - 1, rnd_line(), 1'b0, gw);
    pend_w = 1'b1; w_addr = ADDR_W'($urandom); w_data = rnd_line();
    do_txn(0, TIMEOUT - 1, rnd_line(), 1'b0, gw);
    pend_w = 1'b1; w_addr = ADDR_W'($urandom); w_data = rnd_line();
    do_txn(2, TIMEOUT, rnd_line(), 1'b0, gw);
  endtask

  task automatic test_stray();
    bit gw;
    repeat (3) idle_cycle(1'b1);
    pend_f = 1'b1; f_addr = ADDR_W'($urandom);
    do_txn(2, 3, rnd_line(), 1'b1, gw);
    pend_w = 1'b1; w_addr = ADDR_W'($urandom); w_data = rnd_line();
    do_txn(1, 2, rnd_line(), 1'b1, gw);
  endtask

  task automatic test_reset_mid_wait();
    bit gw;
    w_addr = ADDR_W'($urandom); w_data = rnd_line();
    fill_req = 1'b0; wb_req = 1'b1; wb_addr = w_addr; wb_data = w_data; mem_rdy = 1'b1;
    step();
    vectors++;
    if (st !== {7'b0100011, exp_fill}) begin
      miscompares++; $display("FAIL rmw_grant: got %h want %h", st, {7'b0100011, exp_fill});
    end
    wb_req = 1'b0;
    step();
    mem_rdy = 1'b0;
    step();
    vectors++;
    if (st !== {7'b0000010, exp_fill}) begin
      miscompares++; $display("FAIL rmw_wait: got %h want %h", st, {7'b0000010, exp_fill});
    end
    rst = 1'b0; mem_wack = 1'b1;
    #1;
    vectors++;
    if ({st, mb} !== '0) begin
      miscompares++; $display("FAIL rmw_reset: got %h %h want 0", st, mb);
    end
    step(); step();
    vectors++;
    if ({st, mb} !== '0) begin
      miscompares++; $display("FAIL rmw_reset_hold: got %h %h want 0", st, mb);
    end
    mem_wack = 1'b0; rst = 1'b1;
    step();
    last_wb = 1'b0; exp_fill = '0; pend_f = 1'b0;
    vectors++;
    if (st !== '0) begin
      miscompares++; $display("FAIL rmw_release: got %h want 0", st);
    end
    pend_w = 1'b1;
    do_txn(0, 0, rnd_line(), 1'b0, gw);
  endtask

  task automatic test_random();
    bit gw;
    int unsigned d, r;
    chaos = 1'b1;
    repeat (150) begin
      if (!pend_f && $urandom_range(0, 1) == 1) begin
        pend_f = 1'b1; f_addr = ADDR_W'($urandom);
      end
      if (!pend_w && $urandom_range(0, 1) == 1) begin
        pend_w = 1'b1; w_addr = ADDR_W'($urandom); w_data = rnd_line();
      end
      if (!pend_f && !pend_w) begin
        idle_cycle(1'b0);
      end else begin
        d = $urandom_range(0, 3);
        r = ($urandom_range(0, 5) == 0) ? TIMEOUT + $urandom_range(0, 2)
                                        : $urandom_range(0, TIMEOUT - 1);
        do_txn(d, r, rnd_line(), 1'b0, gw);
      end
    end
    chaos = 1'b0;
  endtask

  initial begin
    fill_req = 1'b0; wb_req = 1'b0; mem_rdy = 1'b0; mem_rvld = 1'b0; mem_wack = 1'b0;
    fill_addr = '0; wb_addr = '0; wb_data = '0; mem_rdata = '0;
    pend_f = 1'b0; pend_w = 1'b0; last_wb = 1'b0; chaos = 1'b0;
    f_addr = '0; w_addr = '0; w_data = '0; exp_fill = '0;
    test_reset();
    test_fill_only();
    test_tie();
    test_backpressure();
    test_timeout();
    test_stray();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
